// File: rtl/freq_meter_if.sv
// Sample-stream and result bundle between a code source and freq_meter.
// master: drives the sample strobe and code, receives fcw/valid/timeout/busy.
// slave : the meter side of the same signals.
interface freq_meter_if;
    logic        next_sample;
    logic [9:0]  code;
    logic [23:0] fcw;
    logic        valid;
    logic        timeout;
    logic        busy;

    modport master (
        output next_sample, code,
        input  fcw, valid, timeout, busy
    );

    modport slave (
        input  next_sample, code,
        output fcw, valid, timeout, busy
    );
endinterface

// File: rtl/freq_meter.sv
// Purpose: measures input tone frequency as an NCO fcw (2^24*f/fs) from NPER rising crossings.
// Latency: result on T+30 after the NPER-th counted crossing (29-cycle restoring divide).
// Backpressure: none; strobe-qualified input, one-cycle valid pulse, fcw/timeout held between pulses.
//
// Ports: clk, rst (sync, active-high); mif.slave carries next_sample/code in and
// fcw/valid/timeout/busy out, all outputs registered.
// Build option: define FREQ_METER_HYST_EN to apply the HYST band around midscale;
// without it the classifier splits at 512 and HYST has no effect.
module freq_meter #(
    parameter int NPER  = 4,
    parameter int HYST  = 16,
    parameter int CNT_W = 24
) (
    input  logic       clk,
    input  logic       rst,
    freq_meter_if.slave mif
);

`ifdef FREQ_METER_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    localparam int          HYST_USE = HYST_ON ? HYST : 0;
    localparam logic [10:0] LO_TH    = 11'(512 - HYST_USE);
    localparam logic [10:0] HI_TH    = 11'(512 + HYST_USE);
    localparam logic [4:0]  NPER_C   = 5'(NPER);
    // Dividend NPER*2^24 needs 29 bits for NPER up to 16.
    localparam logic [28:0] DIVIDEND = 29'(NPER) << 24;
    localparam logic [CNT_W-1:0] S_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    state_t            state;
    logic              level;      // held level, 1 = HIGH
    logic [CNT_W-1:0]  s_cnt;
    logic [4:0]        cross_cnt;
    logic [CNT_W-1:0]  rem;
    logic [27:0]       quo;
    logic [4:0]        bit_idx;
    logic [23:0]       fcw_q;
    logic              valid_q;
    logic              timeout_q;
    logic              busy_q;

    logic              cls_level;
    logic              rise;
    logic [4:0]        cross_nxt;
    logic [CNT_W:0]    rem_sh;
    logic              rem_ge;
    logic [CNT_W-1:0]  rem_nx;
    logic [28:0]       q_nx;
    logic [23:0]       q_sat;

    always_comb begin
        cls_level = level;
        if (mif.next_sample) begin
            if ({1'b0, mif.code} < LO_TH) begin
                cls_level = 1'b0;
            end else if ({1'b0, mif.code} >= HI_TH) begin
                cls_level = 1'b1;
            end
        end
        rise      = mif.next_sample && !level && cls_level;
        cross_nxt = cross_cnt + 5'd1;

        // Restoring step. rem < S always, so the shifted-out MSB means the
        // trial value certainly exceeds S and the low-bit difference is exact.
        rem_sh = {rem, DIVIDEND[bit_idx]};
        rem_ge = rem_sh[CNT_W] || (rem_sh[CNT_W-1:0] >= s_cnt);
        rem_nx = rem_ge ? (rem_sh[CNT_W-1:0] - s_cnt) : rem_sh[CNT_W-1:0];
        q_nx   = {quo, rem_ge};
        q_sat  = (q_nx[28:24] != 5'd0) ? 24'hFFFFFF : q_nx[23:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            level     <= 1'b1;
            s_cnt     <= '0;
            cross_cnt <= '0;
            rem       <= '0;
            quo       <= '0;
            bit_idx   <= '0;
            fcw_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // Held level tracks the input in every state, including DIVIDE.
            if (mif.next_sample) begin
                level <= cls_level;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEASURE;
                        busy_q    <= 1'b1;
                        s_cnt     <= '0;
                        cross_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (mif.next_sample) begin
                        if (s_cnt == S_MAX) begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            fcw_q     <= '0;
                            timeout_q <= 1'b1;
                            valid_q   <= 1'b1;
                        end else begin
                            s_cnt <= s_cnt + CNT_W'(1);
                            if (rise) begin
                                cross_cnt <= cross_nxt;
                                if (cross_nxt == NPER_C) begin
                                    state   <= DIVIDE;
                                    rem     <= '0;
                                    quo     <= '0;
                                    bit_idx <= 5'd28;
                                end
                            end
                        end
                    end
                end
                DIVIDE: begin
                    rem     <= rem_nx;
                    quo     <= q_nx[27:0];
                    bit_idx <= bit_idx - 5'd1;
                    if (bit_idx == 5'd0) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        fcw_q     <= q_sat;
                        timeout_q <= 1'b0;
                        valid_q   <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mif.fcw     = fcw_q;
    assign mif.valid   = valid_q;
    assign mif.timeout = timeout_q;
    assign mif.busy    = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed tone/square/overflow vectors, a transaction-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_freq_meter;
    localparam int NPER  = 4;
    localparam int HYST  = 16;
    localparam int CNT_W = 12;
    localparam int S_LIM = (1 << CNT_W) - 1;

`ifdef FREQ_METER_HYST_EN
    localparam int LO = 512 - HYST;
    localparam int HI = 512 + HYST;
`else
    localparam int LO = 512;
    localparam int HI = 512;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    freq_meter_if mif ();

    freq_meter #(.NPER(NPER), .HYST(HYST), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit busy_seen = 1'b0;
    logic [23:0] ev_fcw[$];
    logic        ev_to[$];

    // Model state and expected outputs
    int          m_mode;   // 0 idle, 1 measuring, 2 dividing
    int          m_s, m_n, m_left;
    bit          m_lvl;
    logic [23:0] e_fcw;
    logic        e_valid, e_to, e_busy;

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit     cls, rise;
        longint q;
        if (rst) begin
            m_mode = 0; m_s = 0; m_n = 0; m_left = 0; m_lvl = 1'b1;
            e_fcw = '0; e_valid = 1'b0; e_to = 1'b0; e_busy = 1'b0;
            return;
        end
        e_valid = 1'b0;
        rise = 1'b0;
        if (mif.next_sample) begin
            cls = m_lvl;
            if (int'(mif.code) < LO) cls = 1'b0;
            else if (int'(mif.code) >= HI) cls = 1'b1;
            rise = !m_lvl && cls;
            m_lvl = cls;
        end
        case (m_mode)
            0: if (rise) begin m_mode = 1; m_s = 0; m_n = 0; end
            1: if (mif.next_sample) begin
                if (m_s + 1 > S_LIM) begin
                    m_mode = 0; e_fcw = '0; e_to = 1'b1; e_valid = 1'b1;
                end else begin
                    m_s++;
                    if (rise) m_n++;
                    if (m_n == NPER) begin m_mode = 2; m_left = 29; end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    q = (longint'(NPER) << 24) / m_s;
                    e_fcw = (q > 64'hFFFFFF) ? 24'hFFFFFF : 24'(q);
                    e_to = 1'b0; e_valid = 1'b1; m_mode = 0;
                end
            end
        endcase
        e_busy = (m_mode != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("valid", {23'd0, mif.valid}, {23'd0, e_valid});
            chk("busy", {23'd0, mif.busy}, {23'd0, e_busy});
            chk("timeout", {23'd0, mif.timeout}, {23'd0, e_to});
            chk("fcw", mif.fcw, e_fcw);
            if (mif.valid === 1'b1) begin
                ev_fcw.push_back(mif.fcw);
                ev_to.push_back(mif.timeout);
            end
            if (mif.busy === 1'b1) busy_seen = 1'b1;
        end
    end

    task automatic cyc1(input bit r, input bit ns, input logic [9:0] c);
        rst = r;
        mif.next_sample = ns;
        mif.code = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc1(1'b1, 1'b0, 10'd512);
        cyc1(1'b1, 1'b0, 10'd512);
        ev_fcw.delete();
        ev_to.delete();
        busy_seen = 1'b0;
    endtask

    function automatic logic [9:0] sine_code(input int ph);
        real a;
        a = 512.0 + 511.0 * $sin(6.283185307179586 * real'(ph) / 16777216.0);
        return 10'($rtoi(a + 0.5));
    endfunction

    task automatic run_sine(input int f, input int sp, input int n);
        int ph;
        logic [9:0] c;
        ph = 0;
        c = 10'd512;
        for (int k = 0; k < n; k++) begin
            if (k % sp == 0) begin
                c = sine_code(ph);
                ph = (ph + f) % (1 << 24);
                cyc1(1'b0, 1'b1, c);
            end else begin
                cyc1(1'b0, 1'b0, c);
            end
        end
    endtask

    // Low, then a start crossing, then 4 LOW/HIGH pairs: S = 8 at the final crossing.
    task automatic square_measure();
        cyc1(1'b0, 1'b1, 10'd0);
        cyc1(1'b0, 1'b1, 10'd1023);
        for (int k = 0; k < 4; k++) begin
            cyc1(1'b0, 1'b1, 10'd0);
            cyc1(1'b0, 1'b1, 10'd1023);
        end
    endtask

    initial begin
        int k;
        bit got;
        rst = 1'b1;
        mif.next_sample = 1'b0;
        mif.code = 10'd512;
        @(negedge clk);
        cyc1(1'b1, 1'b0, 10'd512);
        chk_en = 1'b1;
        do_reset();
        chk("rst_fcw", mif.fcw, 24'h0);
        chk("rst_valid", {23'd0, mif.valid}, 24'd0);
        chk("rst_timeout", {23'd0, mif.timeout}, 24'd0);
        chk("rst_busy", {23'd0, mif.busy}, 24'd0);

        // 256 samples/period
        run_sine(24'h010000, 1, 1700);
        chk("sine256_count", 24'(ev_fcw.size()), 24'd1);
        if (ev_fcw.size() > 0) begin
            chk("sine256_fcw", ev_fcw[0], 24'h010000);
            chk("sine256_to", {23'd0, ev_to[0]}, 24'd0);
        end

        // 16 samples/period, repeated measurements
        do_reset();
        run_sine(24'h100000, 1, 640);
        chk("sine16_count_ge4", {23'd0, ev_fcw.size() >= 4}, 24'd1);
        foreach (ev_fcw[i]) chk($sformatf("sine16_fcw%0d", i), ev_fcw[i], 24'h100000);

        // strobe every third cycle, 64 samples/period
        do_reset();
        run_sine(24'h040000, 3, 1500);
        chk("strobe3_count", 24'(ev_fcw.size()), 24'd1);
        if (ev_fcw.size() > 0) chk("strobe3_fcw", ev_fcw[0], 24'h040000);

        // 500/524 toggle: inside the hysteresis band or not
        do_reset();
        for (int i = 0; i < 60; i++) begin
            cyc1(1'b0, 1'b1, 10'd500);
            cyc1(1'b0, 1'b1, 10'd524);
        end
`ifdef FREQ_METER_HYST_EN
        chk("toggle_busy_seen", {23'd0, busy_seen}, 24'd0);
        chk("toggle_count", 24'(ev_fcw.size()), 24'd0);
`else
        chk("toggle_busy_seen", {23'd0, busy_seen}, 24'd1);
        chk("toggle_count_ge1", {23'd0, ev_fcw.size() >= 1}, 24'd1);
        if (ev_fcw.size() > 0) chk("toggle_fcw", ev_fcw[0], 24'h800000);
`endif

        // exact latency: final crossing on T, result visible on T+30
        do_reset();
        square_measure();
        for (int i = 0; i < 28; i++) cyc1(1'b0, 1'b0, 10'd0);
        chk("lat_busy_t29", {23'd0, mif.busy}, 24'd1);
        chk("lat_valid_t29", {23'd0, mif.valid}, 24'd0);
        cyc1(1'b0, 1'b0, 10'd0);
        chk("lat_valid_t30", {23'd0, mif.valid}, 24'd1);
        chk("lat_fcw_t30", mif.fcw, 24'h800000);
        chk("lat_busy_t30", {23'd0, mif.busy}, 24'd0);
        for (int i = 0; i < 5; i++) cyc1(1'b0, 1'b0, 10'd0);
        chk("hold_fcw", mif.fcw, 24'h800000);
        chk("hold_valid", {23'd0, mif.valid}, 24'd0);

        // reset on the last divide cycle discards the result
        ev_fcw.delete();
        square_measure();
        for (int i = 0; i < 28; i++) cyc1(1'b0, 1'b0, 10'd0);
        cyc1(1'b1, 1'b0, 10'd0);
        chk("rstdiv_valid", {23'd0, mif.valid}, 24'd0);
        chk("rstdiv_busy", {23'd0, mif.busy}, 24'd0);
        chk("rstdiv_fcw", mif.fcw, 24'h0);

        // reset mid-measure
        ev_fcw.delete();
        cyc1(1'b0, 1'b1, 10'd0);
        cyc1(1'b0, 1'b1, 10'd1023);
        cyc1(1'b0, 1'b1, 10'd0);
        cyc1(1'b0, 1'b1, 10'd1023);
        chk("rstmeas_busy_before", {23'd0, mif.busy}, 24'd1);
        cyc1(1'b1, 1'b0, 10'd0);
        chk("rstmeas_busy", {23'd0, mif.busy}, 24'd0);
        chk("rstmeas_fcw", mif.fcw, 24'h0);
        for (int i = 0; i < 40; i++) cyc1(1'b0, 1'b0, 10'd0);
        chk("rstmeas_count", 24'(ev_fcw.size()), 24'd0);

        // counter saturation with CNT_W=12
        do_reset();
        cyc1(1'b0, 1'b1, 10'd0);
        cyc1(1'b0, 1'b1, 10'd1023);
        k = 0;
        got = 1'b0;
        while (!got && k < 4300) begin
            cyc1(1'b0, 1'b1, 10'd0);
            k++;
            if (k == 4095) chk("ovf_busy_4095", {23'd0, mif.busy}, 24'd1);
            if (mif.valid === 1'b1) got = 1'b1;
        end
        chk("ovf_latency", 24'(k), 24'd4096);
        chk("ovf_fcw", mif.fcw, 24'h0);
        chk("ovf_timeout", {23'd0, mif.timeout}, 24'd1);
        chk("ovf_busy", {23'd0, mif.busy}, 24'd0);
        cyc1(1'b0, 1'b0, 10'd0);
        chk("ovf_timeout_hold", {23'd0, mif.timeout}, 24'd1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
